// File: rtl/memory_access_stage_pkg.sv
// Shared pipeline definitions for the memory stage: result-select encodings,
// memory-stage state encoding and the memory-op decode helper.
package memory_access_stage_pkg;

   typedef enum logic [1:0] {
      RES_ALU  = 2'b00,
      RES_LOAD = 2'b01,
      RES_PC4  = 2'b10
   } res_src_e;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ACCESS,
      ST_ERR
   } mem_state_e;

   function automatic logic is_mem_op(input logic       valid,
                                      input logic       mem_write,
                                      input logic [1:0] res_src);
      return valid & (mem_write | (res_src == RES_LOAD));
   endfunction

endpackage

// File: rtl/memory_access_stage_if.sv
// Data-memory request/acknowledge bus between the memory stage (master)
// and the data memory (slave).
interface memory_access_stage_if #(
   parameter int unsigned DATA_WIDTH = 32
);
   logic                  mem_req;
   logic                  mem_we;
   logic [DATA_WIDTH-1:0] mem_addr;
   logic [DATA_WIDTH-1:0] mem_wdata;
   logic                  mem_ack;
   logic [DATA_WIDTH-1:0] mem_rdata;

   modport master (
      output mem_req, mem_we, mem_addr, mem_wdata,
      input  mem_ack, mem_rdata
   );

   modport slave (
      input  mem_req, mem_we, mem_addr, mem_wdata,
      output mem_ack, mem_rdata
   );
endinterface

// File: rtl/memory_access_stage_wb_regfile.sv
// MEM/WB pipeline register: falling-edge, async active-low reset, and a
// bubble input that clears every field instead of capturing.
module memory_writeback_pipeline_regfile #(
   parameter int unsigned DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  bubble,
   input  logic                  valid_d,
   input  logic                  regwrite_d,
   input  logic [1:0]            res_src_d,
   input  logic [DATA_WIDTH-1:0] alu_d,
   input  logic [DATA_WIDTH-1:0] rdata_d,
   input  logic [4:0]            rd_d,
   input  logic [DATA_WIDTH-1:0] pc4_d,
   output logic                  valid_q,
   output logic                  regwrite_q,
   output logic [1:0]            res_src_q,
   output logic [DATA_WIDTH-1:0] alu_q,
   output logic [DATA_WIDTH-1:0] rdata_q,
   output logic [4:0]            rd_q,
   output logic [DATA_WIDTH-1:0] pc4_q
);

   always_ff @(negedge clk or negedge rst_n) begin
      if (!rst_n || bubble) begin
         valid_q    <= 1'b0;
         regwrite_q <= 1'b0;
         res_src_q  <= '0;
         alu_q      <= '0;
         rdata_q    <= '0;
         rd_q       <= '0;
         pc4_q      <= '0;
      end else begin
         valid_q    <= valid_d;
         regwrite_q <= regwrite_d;
         res_src_q  <= res_src_d;
         alu_q      <= alu_d;
         rdata_q    <= rdata_d;
         rd_q       <= rd_d;
         pc4_q      <= pc4_d;
      end
   end

endmodule

// File: rtl/memory_access_stage.sv
// Memory stage: issues data-memory requests for loads/stores, stalls the
// front of the pipeline while an access is outstanding, feeds MEM/WB.
module memory_access_stage
   import memory_access_stage_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned TIMEOUT    = 15
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  valid_i,
   input  logic                  RegWrite_i,
   input  logic [1:0]            ResultsSrc_i,
   input  logic                  MemWrite_i,
   input  logic [DATA_WIDTH-1:0] ALUResult_i,
   input  logic [DATA_WIDTH-1:0] WriteData_i,
   input  logic [4:0]            Rd_i,
   input  logic [DATA_WIDTH-1:0] PCPlus4_i,
   memory_access_stage_if.master mem_bus,
   output logic                  stall_o,
   output logic                  valid_o,
   output logic                  RegWrite_o,
   output logic [1:0]            ResultsSrc_o,
   output logic [DATA_WIDTH-1:0] ALUResult_o,
   output logic [DATA_WIDTH-1:0] ReadData_o,
   output logic [4:0]            Rd_o,
   output logic [DATA_WIDTH-1:0] PCPlus4_o,
   output logic                  err_o
);

   localparam int unsigned CNT_W    = $clog2(TIMEOUT + 1);
   // The IDLE issue cycle is the first request cycle, so ACCESS gives up
   // after TIMEOUT-1 more unacknowledged cycles.
   localparam int unsigned CNT_LAST = (TIMEOUT >= 2) ? TIMEOUT - 2 : 0;

   mem_state_e            state;
   logic [CNT_W-1:0]      cnt;
   logic                  lat_we;
   logic [DATA_WIDTH-1:0] lat_addr;
   logic [DATA_WIDTH-1:0] lat_wdata;
   logic                  lat_regwrite;
   logic [1:0]            lat_res_src;
   logic [4:0]            lat_rd;
   logic [DATA_WIDTH-1:0] lat_pc4;

   logic                  mem_op;
   logic                  req_c;
   logic                  stall_c;
   logic                  wb_bubble;
   logic                  wb_valid;
   logic                  wb_regwrite;
   logic [1:0]            wb_res_src;
   logic [DATA_WIDTH-1:0] wb_alu;
   logic [DATA_WIDTH-1:0] wb_rdata;
   logic [4:0]            wb_rd;
   logic [DATA_WIDTH-1:0] wb_pc4;

   assign mem_op = is_mem_op(valid_i, MemWrite_i, ResultsSrc_i);

   always_comb begin
      req_c            = 1'b0;
      stall_c          = 1'b0;
      mem_bus.mem_we    = lat_we;
      mem_bus.mem_addr  = lat_addr;
      mem_bus.mem_wdata = lat_wdata;
      wb_bubble        = 1'b0;
      wb_valid         = 1'b0;
      wb_regwrite      = 1'b0;
      wb_res_src       = ResultsSrc_i;
      wb_alu           = ALUResult_i;
      wb_rdata         = '0;
      wb_rd            = Rd_i;
      wb_pc4           = PCPlus4_i;
      unique case (state)
         ST_IDLE: begin
            if (mem_op) begin
               req_c             = 1'b1;
               mem_bus.mem_we    = MemWrite_i;
               mem_bus.mem_addr  = ALUResult_i;
               mem_bus.mem_wdata = WriteData_i;
               stall_c           = !mem_bus.mem_ack;
               if (mem_bus.mem_ack) begin
                  wb_valid    = 1'b1;
                  wb_regwrite = RegWrite_i & ~MemWrite_i;
                  wb_rdata    = MemWrite_i ? '0 : mem_bus.mem_rdata;
               end else begin
                  wb_bubble = 1'b1;
               end
            end else begin
               wb_valid    = valid_i;
               wb_regwrite = RegWrite_i & valid_i;
            end
         end
         ST_ACCESS: begin
            req_c      = 1'b1;
            stall_c    = !mem_bus.mem_ack;
            wb_res_src = lat_res_src;
            wb_alu     = lat_addr;
            wb_rd      = lat_rd;
            wb_pc4     = lat_pc4;
            if (mem_bus.mem_ack) begin
               wb_valid    = 1'b1;
               wb_regwrite = lat_regwrite & ~lat_we;
               wb_rdata    = lat_we ? '0 : mem_bus.mem_rdata;
            end else begin
               wb_bubble = 1'b1;
            end
         end
         ST_ERR: begin
            stall_c   = 1'b1;
            wb_bubble = 1'b1;
         end
         default: wb_bubble = 1'b1;
      endcase
   end

   // Gated by reset so the request and stall drop the instant reset asserts,
   // even while the EX/MEM slot still presents a memory op.
   assign mem_bus.mem_req = rst_n & req_c;
   assign stall_o         = rst_n & stall_c;

   always_ff @(negedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= ST_IDLE;
         cnt          <= '0;
         err_o        <= 1'b0;
         lat_we       <= 1'b0;
         lat_addr     <= '0;
         lat_wdata    <= '0;
         lat_regwrite <= 1'b0;
         lat_res_src  <= '0;
         lat_rd       <= '0;
         lat_pc4      <= '0;
      end else begin
         unique case (state)
            ST_IDLE: begin
               if (mem_op && !mem_bus.mem_ack) begin
                  lat_we       <= MemWrite_i;
                  lat_addr     <= ALUResult_i;
                  lat_wdata    <= WriteData_i;
                  lat_regwrite <= RegWrite_i;
                  lat_res_src  <= ResultsSrc_i;
                  lat_rd       <= Rd_i;
                  lat_pc4      <= PCPlus4_i;
                  cnt          <= '0;
                  state        <= ST_ACCESS;
               end
            end
            ST_ACCESS: begin
               if (mem_bus.mem_ack) begin
                  state <= ST_IDLE;
               end else begin
                  cnt <= cnt + CNT_W'(1);
                  if (cnt >= CNT_W'(CNT_LAST)) begin
                     err_o <= 1'b1;
                     state <= ST_ERR;
                  end
               end
            end
            ST_ERR:  state <= ST_ERR;
            default: state <= ST_IDLE;
         endcase
      end
   end

   memory_writeback_pipeline_regfile #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_mem_wb (
      .clk        (clk),
      .rst_n      (rst_n),
      .bubble     (wb_bubble),
      .valid_d    (wb_valid),
      .regwrite_d (wb_regwrite),
      .res_src_d  (wb_res_src),
      .alu_d      (wb_alu),
      .rdata_d    (wb_rdata),
      .rd_d       (wb_rd),
      .pc4_d      (wb_pc4),
      .valid_q    (valid_o),
      .regwrite_q (RegWrite_o),
      .res_src_q  (ResultsSrc_o),
      .alu_q      (ALUResult_o),
      .rdata_q    (ReadData_o),
      .rd_q       (Rd_o),
      .pc4_q      (PCPlus4_o)
   );

endmodule
